// File: rtl/vga_timing_pkg.sv
// Shared types and default timing for the VGA/DVI timing generator.
// The defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;

    // Horizontal timing in pixel clocks
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    // Vertical timing in lines
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // Default pixel-generator latency and colour depth
    localparam int VGA_PIX_LAT  = 2;
    localparam int VGA_COLOR_W  = 8;

    // One pixel at the default colour depth
    typedef struct packed {
        logic [VGA_COLOR_W-1:0] r;
        logic [VGA_COLOR_W-1:0] g;
        logic [VGA_COLOR_W-1:0] b;
    } rgb_t;

    // Test-pattern bars; the encoding is the {R,G,B} on/off triple
    typedef enum logic [2:0] {
        BAR_BLACK   = 3'b000,
        BAR_BLUE    = 3'b001,
        BAR_GREEN   = 3'b010,
        BAR_CYAN    = 3'b011,
        BAR_RED     = 3'b100,
        BAR_MAGENTA = 3'b101,
        BAR_YELLOW  = 3'b110,
        BAR_WHITE   = 3'b111
    } bar_color_e;

endpackage

// File: rtl/vga_delay_line.sv
// Resettable shift register used to align sync/blank/bar with the
// external pixel pipeline. DEPTH=0 degenerates to a plain wire.
module vga_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         vgaclk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Clock and reset have no job without stages
            logic unused_ctrl;
            assign unused_ctrl = vgaclk ^ reset;
            assign dout        = din;
        end else begin : g_shift
            logic [W-1:0] stage [DEPTH];

            // Shift the raw timing word one stage per pixel clock
            always_ff @(posedge vgaclk or posedge reset) begin
                if (reset) begin
                    // NOTE: every stage is cleared, not just the head, so that
                    // no stale sync or data-enable leaks out after reset.
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI timing generator. Owns the h/v counters, issues
// (x,y) to the pixel generator and re-aligns sync/blank with the returned
// colour after the generator's PIX_LAT-cycle pipeline. Optional colour bars.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int PIX_LAT   = VGA_PIX_LAT,
    parameter int COLOR_W   = VGA_COLOR_W,
    localparam int HTOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int VTOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int CNT_W    = $clog2((HTOTAL > VTOTAL) ? HTOTAL : VTOTAL)
) (
    input  logic               vgaclk,
    input  logic               reset,
    input  logic               pattern_en,
    input  logic [COLOR_W-1:0] r_in,
    input  logic [COLOR_W-1:0] g_in,
    input  logic [COLOR_W-1:0] b_in,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               active,
    output logic               line_start,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync,
    output logic               sync_b,
    output logic               blank_b,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b
);

    localparam logic [CNT_W-1:0]   H_LAST   = CNT_W'(HTOTAL - 1);
    localparam logic [CNT_W-1:0]   V_LAST   = CNT_W'(VTOTAL - 1);
    localparam int                 HS_START = H_ACTIVE + H_FP;
    localparam int                 HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int                 VS_START = V_ACTIVE + V_FP;
    localparam int                 VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam logic [CNT_W+2:0]   H_ACT_W  = (CNT_W+3)'(H_ACTIVE);

    logic [CNT_W-1:0] hcnt, vcnt;
    logic             raw_hs, raw_vs, raw_de;
    bar_color_e       bar;
    logic [CNT_W+2:0] bar_prod;
    logic             d_hs, d_vs, d_de;
    logic [2:0]       d_bar;

    // Raster position: hcnt sweeps a line, vcnt advances on each line wrap
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            // NOTE: state registers use <= so each one sees the pre-edge
            // value of the others regardless of statement order.
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    // hcnt*8 is held in CNT_W+3 bits so the bar product never overflows
    assign bar_prod = {hcnt, 3'b000};

    // Decode raw (undelayed) sync, data-enable and bar colour from the counters
    always_comb begin
        // NOTE: defaults come first so every path assigns every output and
        // no latch can be inferred.
        raw_hs = 1'b0;
        raw_vs = 1'b0;
        raw_de = 1'b0;
        bar    = BAR_BLACK;
        if (int'(hcnt) >= HS_START && int'(hcnt) < HS_END) raw_hs = 1'b1;
        if (int'(vcnt) >= VS_START && int'(vcnt) < VS_END) raw_vs = 1'b1;
        if (int'(hcnt) < H_ACTIVE && int'(vcnt) < V_ACTIVE) raw_de = 1'b1;
        bar = bar_color_e'(3'(bar_prod / H_ACT_W));
    end

    assign x           = hcnt;
    assign y           = vcnt;
    assign active      = raw_de;
    assign line_start  = (hcnt == '0);
    assign frame_start = (hcnt == '0) && (vcnt == '0);

    // Timing word travels the same latency as the external pixel pipeline
    vga_delay_line #(
        .W     (6),
        .DEPTH (PIX_LAT)
    ) u_delay (
        .vgaclk (vgaclk),
        .reset  (reset),
        .din    ({raw_hs, raw_vs, raw_de, bar}),
        .dout   ({d_hs, d_vs, d_de, d_bar})
    );

    // Output register: apply sync polarity, choose pattern or input, blank outside de
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            hsync   <= !HSYNC_POL;
            vsync   <= !VSYNC_POL;
            sync_b  <= 1'b1;
            blank_b <= 1'b0;
            r       <= '0;
            g       <= '0;
            b       <= '0;
        end else begin
            hsync   <= d_hs ? HSYNC_POL : !HSYNC_POL;
            vsync   <= d_vs ? VSYNC_POL : !VSYNC_POL;
            sync_b  <= !(d_hs || d_vs);
            blank_b <= d_de;
            if (!d_de) begin
                r <= '0;
                g <= '0;
                b <= '0;
            end else if (pattern_en) begin
                r <= {COLOR_W{d_bar[2]}};
                g <= {COLOR_W{d_bar[1]}};
                b <= {COLOR_W{d_bar[0]}};
            end else begin
                r <= r_in;
                g <= g_in;
                b <= b_in;
            end
        end
    end

endmodule
